// File: rtl/if_stage_pkg.sv
// Shared fetch-pipeline types and constants for the IF stage and its PC generator.
// Read by if_stage; the IF_PERF_CNT_EN build option does not change anything in this file.
package if_stage_pkg;

    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] sum;
        logic [31:0] instr;
        logic        valid;
    } ifid_entry_t;

    function automatic ifid_entry_t ifid_reset_entry(input logic [31:0] nop);
        ifid_entry_t e;
        e.pc    = 32'h0;
        e.sum   = 32'h0;
        e.instr = nop;
        e.valid = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/if_stage_fetch_pc_gen.sv
// PC register with +4 adder and next-PC selection (hold / increment / redirect target).
// PC arithmetic wraps modulo 2^32; low address bits are carried through untouched.
module fetch_pc_gen
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     sel_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_INC:    pc_d = pc_plus4;
            PC_TARGET: pc_d = target_i;
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch FSM, hold buffer, redirect drain and the IF/ID register.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_bubble_cnt counter outputs.
//
//   state | meaning
//   FETCH | request outstanding at pc, accept or bubble each cycle
//   HOLD  | response captured during a stall, request dropped until release
//   DRAIN | redirect arrived before the response; wait it out at the old address
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        hazard_detection,
    input  logic        NextPCSrc,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_out,
    output logic [31:0] sum_out,
    output logic [31:0] instr_out,
    output logic        valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    ifid_entry_t  ifid_q;
    logic [31:0]  hold_q;
    logic [31:0]  target_q;

    pc_sel_e      pc_sel;
    logic [31:0]  pc_target;
    logic [31:0]  pc_q;
    logic [31:0]  pc_plus4;

    logic         load_real;
    logic         load_bubble;
    logic [31:0]  load_instr;
    logic         hold_we;
    logic         target_we;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk        (clk),
        .rst        (rst),
        .sel_i      (pc_sel),
        .target_i   (pc_target),
        .pc_o       (pc_q),
        .pc_plus4_o (pc_plus4)
    );

    // The request is a pure function of state so address and req stay put until ready.
    assign imem_req  = ~rst & (state_q != HOLD);
    assign imem_addr = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_sel      = PC_HOLD;
        pc_target   = branch_target;
        load_real   = 1'b0;
        load_bubble = 1'b0;
        load_instr  = imem_rdata;
        hold_we     = 1'b0;
        target_we   = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (NextPCSrc) begin
                        pc_sel      = PC_TARGET;
                        load_bubble = 1'b1;
                    end else if (hazard_detection) begin
                        hold_we = 1'b1;
                        state_d = HOLD;
                    end else begin
                        pc_sel    = PC_INC;
                        load_real = 1'b1;
                    end
                end else begin
                    if (NextPCSrc) begin
                        target_we   = 1'b1;
                        load_bubble = 1'b1;
                        state_d     = DRAIN;
                    end else if (!hazard_detection) begin
                        load_bubble = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (NextPCSrc) begin
                    pc_sel      = PC_TARGET;
                    load_bubble = 1'b1;
                    state_d     = FETCH;
                end else if (!hazard_detection) begin
                    pc_sel     = PC_INC;
                    load_real  = 1'b1;
                    load_instr = hold_q;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                target_we   = NextPCSrc;
                load_bubble = NextPCSrc | ~hazard_detection;
                if (imem_ready) begin
                    // A redirect landing on the same cycle as the orphan is the newest target.
                    pc_sel    = PC_TARGET;
                    pc_target = NextPCSrc ? branch_target : target_q;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            ifid_q   <= ifid_reset_entry(NOP_INSTR);
            hold_q   <= 32'h0;
            target_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (hold_we) begin
                hold_q <= imem_rdata;
            end
            if (target_we) begin
                target_q <= branch_target;
            end
            if (load_real) begin
                ifid_q.pc    <= pc_q;
                ifid_q.sum   <= pc_plus4;
                ifid_q.instr <= load_instr;
                ifid_q.valid <= 1'b1;
            end else if (load_bubble) begin
                ifid_q.instr <= NOP_INSTR;
                ifid_q.valid <= 1'b0;
            end
        end
    end

    assign pc_out    = ifid_q.pc;
    assign sum_out   = ifid_q.sum;
    assign instr_out = ifid_q.instr;
    assign valid_out = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= 32'h0;
            perf_bubble_q <= 32'h0;
        end else begin
            if (load_real) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (load_bubble) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random traffic against a transaction-level model.
// Also checks the perf counters when built with IF_PERF_CNT_EN.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MKEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        hazard_detection;
    logic        NextPCSrc;
    logic [31:0] branch_target;
    logic [31:0] pc_out;
    logic [31:0] sum_out;
    logic [31:0] instr_out;
    logic        valid_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .hazard_detection (hazard_detection),
        .NextPCSrc        (NextPCSrc),
        .branch_target    (branch_target),
        .pc_out           (pc_out),
        .sum_out          (sum_out),
        .instr_out        (instr_out),
        .valid_out        (valid_out)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_bubble_cnt  (perf_bubble_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: where fetch is, whether a captured word is parked, whether an orphan is pending.
    logic [31:0] m_pc;
    bit          m_parked;
    logic [31:0] m_parked_word;
    bit          m_orphan;
    logic [31:0] m_orphan_dest;
    logic [31:0] e_pc, e_sum, e_instr;
    logic        e_valid;
    int unsigned e_fetches, e_bubbles;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ MKEY;
    endfunction

    function automatic void m_bubble();
        e_valid = 1'b0;
        e_instr = NOP;
        e_bubbles++;
    endfunction

    function automatic void m_deliver(input logic [31:0] w);
        e_pc    = m_pc;
        e_sum   = m_pc + 32'd4;
        e_instr = w;
        e_valid = 1'b1;
        e_fetches++;
        m_pc    = m_pc + 32'd4;
    endfunction

    function automatic void m_step(input bit r, input bit rdy, input bit st, input bit rd,
                                   input logic [31:0] t);
        if (r) begin
            m_pc = 32'h0; m_parked = 0; m_orphan = 0;
            e_pc = 32'h0; e_sum = 32'h0; e_instr = NOP; e_valid = 1'b0;
            e_fetches = 0; e_bubbles = 0;
        end else if (m_parked) begin
            if (rd) begin m_pc = t; m_parked = 0; m_bubble(); end
            else if (!st) begin m_deliver(m_parked_word); m_parked = 0; end
        end else if (m_orphan) begin
            if (rd) m_orphan_dest = t;
            if (rd || !st) m_bubble();
            if (rdy) begin m_pc = m_orphan_dest; m_orphan = 0; end
        end else if (rdy) begin
            if (rd) begin m_pc = t; m_bubble(); end
            else if (st) begin m_parked_word = mem_word(m_pc); m_parked = 1; end
            else m_deliver(mem_word(m_pc));
        end else begin
            if (rd) begin m_orphan_dest = t; m_orphan = 1; m_bubble(); end
            else if (!st) m_bubble();
        end
    endfunction

    task automatic step(input bit r, input bit rdy, input bit st, input bit rd, input logic [31:0] t);
        rst              = r;
        imem_ready       = rdy;
        hazard_detection = st;
        NextPCSrc        = rd;
        branch_target    = t;
        imem_rdata       = rdy ? mem_word(imem_addr) : $urandom;
        @(posedge clk);
        m_step(r, rdy, st, rd, t);
        #1;
        check("imem_req", {31'h0, imem_req}, {31'h0, ~r & ~m_parked});
        check("imem_addr", imem_addr, m_pc);
        check("pc_out", pc_out, e_pc);
        check("sum_out", sum_out, e_sum);
        check("instr_out", instr_out, e_instr);
        check("valid_out", {31'h0, valid_out}, {31'h0, e_valid});
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, e_fetches);
        check("perf_bubble_cnt", perf_bubble_cnt, e_bubbles);
`endif
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
        hazard_detection = 1'b0; NextPCSrc = 1'b0; branch_target = 32'h0;
        m_pc = 32'h0; m_parked = 0; m_parked_word = 32'h0; m_orphan = 0; m_orphan_dest = 32'h0;
        e_pc = 32'h0; e_sum = 32'h0; e_instr = NOP; e_valid = 1'b0; e_fetches = 0; e_bubbles = 0;

        step(1, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'h0);   // streams 0x0..0xC, pc now 0x10
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 32'h0);   // capture 0x10 then hold 3 cycles
        step(0, 0, 0, 0, 32'h0);                               // release: 0x10 delivered once
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0);   // 0x14..0x1C
        step(0, 1, 0, 1, 32'h100);                             // ready at 0x20 plus redirect
        step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 1, 32'h30);
        step(0, 0, 0, 1, 32'h200);                             // orphan at 0x30
        step(0, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);                               // orphan dropped, go 0x200
        step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0);   // wrap past 0xFFFF_FFFC
        step(0, 0, 0, 1, 32'h400);
        step(0, 0, 1, 1, 32'h500);                             // second redirect in drain
        step(0, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);                               // reset mid-request
        step(0, 1, 0, 0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            bit          r, rdy, st, rd;
            logic [31:0] t;
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            t   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step(r, rdy, st, rd, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
